// File: rtl/pad_dir_sequencer.sv
// Bidirectional pad direction sequencer: owns pad output-enable, drive
// strength and pulls, inserts a tri-state gap on every direction change and
// synchronizes the asynchronous pad input with edge detection.
module pad_dir_sequencer #(
  parameter int unsigned TurnCycles      = 2,
  parameter int unsigned SyncStages      = 2,
  parameter logic [3:0]  DefaultStrength = 4'h4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_dir_out_i,
  input  logic [3:0] req_strength_i,
  input  logic [1:0] req_pull_i,
  input  logic       out_data_i,
  output logic       in_data_o,
  output logic       in_rise_o,
  output logic       in_fall_o,
  output logic       busy_o,
  output logic       pad_data_o,
  output logic       pad_oe_no,
  output logic [3:0] pad_strength_o,
  output logic       pad_pullup_en_o,
  output logic       pad_pulldown_en_o,
  input  logic       pad_data_i
);

  typedef enum logic [1:0] {
    ST_IN          = 2'd0,
    ST_OUT         = 2'd1,
    ST_TURN_TO_OUT = 2'd2,
    ST_TURN_TO_IN  = 2'd3
  } state_t;

  // Counter counts down the remaining gap cycles after the entry cycle.
  localparam logic [3:0] TurnLoad = 4'(TurnCycles - 1);

  state_t               state_reg, state_next;
  logic [3:0]           turn_cnt_reg, turn_cnt_next;
  logic                 accept;

  logic                 oe_n_reg, oe_n_next;
  logic                 data_reg, data_next;
  logic [3:0]           strength_reg, strength_next;
  logic                 pullup_reg, pullup_next;
  logic                 pulldown_reg, pulldown_next;
  logic                 rise_reg, rise_next;
  logic                 fall_reg, fall_next;
  logic [SyncStages-1:0] sync_reg;

  assign req_ready_o = (state_reg == ST_IN) || (state_reg == ST_OUT);
  assign busy_o      = (state_reg == ST_TURN_TO_OUT) || (state_reg == ST_TURN_TO_IN);
  assign accept      = req_valid_i && req_ready_o;

  // State register and turnaround counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= ST_IN;
      turn_cnt_reg <= 4'd0;
    end else begin
      state_reg    <= state_next;
      turn_cnt_reg <= turn_cnt_next;
    end
  end

  // Next-state logic: only a direction change starts a turnaround; the gap
  // ends when the counter has reached zero (it never wraps).
  always_comb begin
    state_next    = state_reg;
    turn_cnt_next = turn_cnt_reg;
    case (state_reg)
      ST_IN: begin
        if (accept && req_dir_out_i) begin
          state_next    = ST_TURN_TO_OUT;
          turn_cnt_next = TurnLoad;
        end
      end
      ST_OUT: begin
        if (accept && !req_dir_out_i) begin
          state_next    = ST_TURN_TO_IN;
          turn_cnt_next = TurnLoad;
        end
      end
      ST_TURN_TO_OUT: begin
        if (turn_cnt_reg == 4'd0) state_next = ST_OUT;
        else                      turn_cnt_next = turn_cnt_reg - 4'd1;
      end
      ST_TURN_TO_IN: begin
        if (turn_cnt_reg == 4'd0) state_next = ST_IN;
        else                      turn_cnt_next = turn_cnt_reg - 4'd1;
      end
      default: state_next = ST_IN;
    endcase
  end

  // Output logic: next values of the registered pad controls are derived
  // from the next state, so drive is enabled only while the state is OUT.
  always_comb begin
    oe_n_next     = (state_next != ST_OUT);
    data_next     = (state_next == ST_OUT) ? out_data_i : 1'b0;
    strength_next = accept ? req_strength_i : strength_reg;
    pullup_next   = pullup_reg;
    pulldown_next = pulldown_reg;
    if ((state_next == ST_OUT) || (state_next == ST_TURN_TO_OUT)) begin
      pullup_next   = 1'b0;
      pulldown_next = 1'b0;
    end else if (accept) begin
      // Encoding 11 decodes to neither pull, so both can never be set.
      pullup_next   = (req_pull_i == 2'b01);
      pulldown_next = (req_pull_i == 2'b10);
    end
    rise_next = !sync_reg[SyncStages-1] &&  sync_reg[SyncStages-2];
    fall_next =  sync_reg[SyncStages-1] && !sync_reg[SyncStages-2];
  end

  // Registered pad controls and edge pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oe_n_reg     <= 1'b1;
      data_reg     <= 1'b0;
      strength_reg <= DefaultStrength;
      pullup_reg   <= 1'b0;
      pulldown_reg <= 1'b0;
      rise_reg     <= 1'b0;
      fall_reg     <= 1'b0;
    end else begin
      oe_n_reg     <= oe_n_next;
      data_reg     <= data_next;
      strength_reg <= strength_next;
      pullup_reg   <= pullup_next;
      pulldown_reg <= pulldown_next;
      rise_reg     <= rise_next;
      fall_reg     <= fall_next;
    end
  end

  // Input synchronizer chain; stage 0 samples the asynchronous pad input.
  for (genvar gi = 0; gi < SyncStages; gi++) begin : g_sync
    // One synchronizer stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sync_reg[gi] <= 1'b0;
      else if (gi == 0) sync_reg[gi] <= pad_data_i;
      else sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
    end
  end

  assign in_data_o         = sync_reg[SyncStages-1];
  // Edge pulses line up with the in_data_o transition and are masked outside IN.
  assign in_rise_o         = rise_reg && (state_reg == ST_IN);
  assign in_fall_o         = fall_reg && (state_reg == ST_IN);
  assign pad_data_o        = data_reg;
  assign pad_oe_no         = oe_n_reg;
  assign pad_strength_o    = strength_reg;
  assign pad_pullup_en_o   = pullup_reg;
  assign pad_pulldown_en_o = pulldown_reg;

endmodule

// File: doc/pad_dir_sequencer.md
PAD_DIR_SEQUENCER -- requirements
Module: pad_dir_sequencer

Interface
REQ-001 SHALL have parameter TurnCycles, default 2, tri-state gap cycles on any direction change; legal range 1..15.
REQ-002 SHALL have parameter SyncStages, default 2, input synchronizer depth; legal range 2..4.
REQ-003 SHALL have parameter DefaultStrength, default 4'h4, drive strength applied at reset.
REQ-004 SHALL have port clk_i  input  1  single clock, all state rising-edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid_i  input  1  config request valid.
REQ-007 SHALL have port req_ready_o  output  1  config request accepted when high with valid.
REQ-008 SHALL have port req_dir_out_i  input  1  1 = drive pad, 0 = receive.
REQ-009 SHALL have port req_strength_i  input  4  requested drive strength.
REQ-010 SHALL have port req_pull_i  input  2  00 none, 01 pull-up, 10 pull-down, 11 none.
REQ-011 SHALL have port out_data_i  input  1  data to drive when in output mode.
REQ-012 SHALL have port in_data_o  output  1  synchronized pad input.
REQ-013 SHALL have port in_rise_o / in_fall_o  output  1 each  single-cycle edge pulses.
REQ-014 SHALL have port busy_o  output  1  high during turnaround.
REQ-015 SHALL have port pad_data_o  output  1  to pad cell data input.
REQ-016 SHALL have port pad_oe_no  output  1  to pad cell output-enable, active-low.
REQ-017 SHALL have port pad_strength_o  output  4  to pad cell drive strength.
REQ-018 SHALL have ports pad_pullup_en_o, pad_pulldown_en_o  output  1 each  to pad cell pulls.
REQ-019 SHALL have port pad_data_i  input  1  from pad cell data output (asynchronous).

Function
REQ-020 SHALL implement FSM states IN, OUT, TURN_TO_OUT, TURN_TO_IN; all pad_* outputs registered.
REQ-021 SHALL drive req_ready_o = 1 only in IN or OUT; busy_o = 1 only in TURN_* states.
REQ-022 Accepted request with same direction as current state: SHALL update pad_strength_o and pulls next cycle, no state change, ready stays high.
REQ-023 Accepted dir_out=1 in IN: next cycle TURN_TO_OUT with pad_oe_no=1, pulls cleared; after TurnCycles cycles in TURN_TO_OUT, enter OUT with pad_oe_no=0.
REQ-024 Accepted dir_out=0 in OUT: next cycle pad_oe_no=1 (drive released immediately) and requested pulls applied, state TURN_TO_IN; after TurnCycles cycles enter IN.
REQ-025 Turn counter SHALL load TurnCycles-1 on acceptance and decrement to 0; exit on 0; no wrap.
REQ-026 req_pull_i=11 SHALL map to both pulls off; pulls SHALL never be simultaneously 1.
REQ-027 In OUT and TURN_TO_OUT both pulls SHALL be 0 regardless of request.
REQ-028 pad_data_o SHALL be out_data_i registered (1-cycle latency) in OUT, 0 in all other states.
REQ-029 pad_oe_no=0 SHALL only occur in OUT; never in the cycle a TURN_* state is entered.
REQ-030 pad_data_i SHALL pass SyncStages flops; in_data_o = last stage; latency SyncStages cycles.
REQ-031 in_rise_o/in_fall_o SHALL pulse one cycle on 0->1 / 1->0 of last two stages, only in state IN; 0 otherwise.
REQ-032 Requests with valid high while ready low SHALL be held off (not dropped); requester holds payload stable.
REQ-033 Strength SHALL be latched for any accepted request, applied even while in TURN_* states.

Reset
REQ-034 On rst_ni low, immediately: state IN, pad_oe_no=1, pad_data_o=0, pad_strength_o=DefaultStrength, pulls 0, synchronizer flops 0, edges 0, busy_o=0, req_ready_o=1.
REQ-035 Reset mid-turnaround SHALL abort to IN with pad released; no drive glitch.

Verification
REQ-036 Reset release, no requests -> pad_oe_no=1, strength 4'h4, ready=1, pulls 0.
REQ-037 IN, accept dir_out=1 at edge k, TurnCycles=2 -> busy high k+1..k+2, pad_oe_no=0 and ready=1 from k+3; pad_data_o tracks out_data_i one cycle late.
REQ-038 OUT, accept dir_out=0 pull=01 at edge k -> pad_oe_no=1 and pullup=1 at k+1, IN reached k+3.
REQ-039 IN, pull=11 strength 4'hF -> both pulls 0, pad_strength_o=4'hF next cycle, no busy.
REQ-040 IN, pad_data_i toggles 0->1->0 -> in_data_o follows after 2 cycles, one in_rise_o and one in_fall_o pulse; none during OUT.
REQ-041 rst_ni low during TURN_TO_OUT -> pad_oe_no=1 asynchronously, state IN after release, pad never driven.
